// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared register map, STATUS/CTRL bit positions and sequencer state types
// for the UART FIFO controller.
package uart_fifo_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLKDIV = 2'd3;

  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_RX_FULL   = 2;
  localparam int unsigned ST_RX_EMPTY  = 3;
  localparam int unsigned ST_TX_OVF    = 4;
  localparam int unsigned ST_RX_OVF    = 5;
  localparam int unsigned ST_TX_ACTIVE = 6;

  localparam int unsigned CT_IE_RX     = 0;
  localparam int unsigned CT_IE_TX     = 1;
  localparam int unsigned CT_IE_ERR    = 2;
  localparam int unsigned CT_CFG_LSB   = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_DRAIN
  } rx_state_e;

endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push at full and pop at empty
// are ignored, decided on the pre-edge flags.
module sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic [W-1:0]  head_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Bus-facing UART sequencer: TX/RX byte FIFOs, core write/busy and
// ready/ack handshakes, baud/frame configuration and a level interrupt.
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int unsigned CLK_WIDTH = 16,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stb,
  output logic                 ack,
  input  logic                 we,
  input  logic [1:0]           addr,
  input  logic [31:0]          dtw,
  output logic [31:0]          dtr,
  output logic                 irq,
  output logic [7:0]           u_data_o,
  output logic                 u_write_o,
  input  logic                 u_busy_i,
  input  logic [7:0]           u_data_i,
  input  logic                 u_ready_i,
  output logic                 u_ack_o,
  output logic [CLK_WIDTH-1:0] u_clkdiv_o,
  output logic [2:0]           u_cfg_o
);

  tx_state_e            tx_state_q, tx_state_d;
  rx_state_e            rx_state_q, rx_state_d;
  logic                 tx_ovf_q, tx_ovf_d;
  logic                 rx_ovf_q, rx_ovf_d;
  logic [5:0]           ctrl_q, ctrl_d;
  logic [CLK_WIDTH-1:0] clkdiv_q, clkdiv_d;
  logic                 irq_q, irq_d;

  logic                 bus_data_wr, bus_data_rd, bus_stat_wr, bus_ctrl_wr, bus_div_wr;
  logic                 tx_full, tx_empty, tx_pop, tx_active;
  logic                 rx_full, rx_empty, rx_push;
  logic [FIFO_AW:0]     tx_count, rx_count;
  logic [7:0]           tx_head, rx_head;
  logic                 unused_dtw;

  assign bus_data_wr = stb && we  && (addr == ADDR_DATA);
  assign bus_data_rd = stb && !we && (addr == ADDR_DATA);
  assign bus_stat_wr = stb && we  && (addr == ADDR_STATUS);
  assign bus_ctrl_wr = stb && we  && (addr == ADDR_CTRL);
  assign bus_div_wr  = stb && we  && (addr == ADDR_CLKDIV);
  assign unused_dtw  = ^dtw;

  assign tx_pop    = (tx_state_q == TX_START);
  assign tx_active = (tx_state_q != TX_IDLE);
  assign rx_push   = (rx_state_q == RX_IDLE) && u_ready_i;

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (bus_data_wr),
    .data_i  (dtw[7:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .head_o  (tx_head)
  );

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (rx_push),
    .data_i  (u_data_i),
    .pop_i   (bus_data_rd),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count),
    .head_o  (rx_head)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:    if (!tx_empty && !u_busy_i) tx_state_d = TX_START;
      TX_START:   tx_state_d = TX_WAIT_HI;
      TX_WAIT_HI: if (u_busy_i) tx_state_d = TX_WAIT_LO;
      TX_WAIT_LO: if (!u_busy_i) tx_state_d = TX_IDLE;
      default:    tx_state_d = TX_IDLE;
    endcase

    // DRAIN blocks a second capture while the core still holds ready.
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (u_ready_i) rx_state_d = RX_DRAIN;
      RX_DRAIN: if (!u_ready_i) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (bus_stat_wr && dtw[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (bus_stat_wr && dtw[ST_RX_OVF]) rx_ovf_d = 1'b0;
    if (bus_data_wr && tx_full) tx_ovf_d = 1'b1;
    if (rx_push && rx_full)     rx_ovf_d = 1'b1;

    ctrl_d   = bus_ctrl_wr ? dtw[5:0] : ctrl_q;
    clkdiv_d = bus_div_wr ? dtw[CLK_WIDTH-1:0] : clkdiv_q;

    irq_d = (ctrl_q[CT_IE_RX] && !rx_empty)
          || (ctrl_q[CT_IE_TX] && tx_empty && !tx_active)
          || (ctrl_q[CT_IE_ERR] && (tx_ovf_q || rx_ovf_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      ctrl_q     <= '0;
      clkdiv_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      ctrl_q     <= ctrl_d;
      clkdiv_q   <= clkdiv_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    dtr = '0;
    case (addr)
      ADDR_DATA: dtr[7:0] = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS: begin
        dtr[6:0]   = {tx_active, rx_ovf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};
        dtr[11:8]  = 4'(tx_count);
        dtr[15:12] = 4'(rx_count);
      end
      ADDR_CTRL:   dtr[5:0] = ctrl_q;
      ADDR_CLKDIV: dtr[CLK_WIDTH-1:0] = clkdiv_q;
      default:     dtr = '0;
    endcase
  end

  assign ack        = 1'b1;
  assign irq        = irq_q;
  assign u_data_o   = tx_head;
  assign u_write_o  = tx_pop;
  assign u_ack_o    = rx_push;
  assign u_clkdiv_o = clkdiv_q;
  assign u_cfg_o    = ctrl_q[5:CT_CFG_LSB];

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: queue-based reference model, core
// emulation for busy/ready handshakes, monitor checking bus reads and TX bytes.
module tb_uart_fifo_ctrl;

  localparam int CW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stb = 1'b0, we = 1'b0;
  logic [1:0]    addr = '0;
  logic [31:0]   dtw = '0;
  logic          ack, irq, u_write_o, u_ack_o;
  logic [31:0]   dtr;
  logic [7:0]    u_data_o;
  logic          u_busy_i = 1'b0;
  logic [7:0]    u_data_i = '0;
  logic          u_ready_i = 1'b0;
  logic [CW-1:0] u_clkdiv_o;
  logic [2:0]    u_cfg_o;

  uart_fifo_ctrl #(.CLK_WIDTH(CW), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .stb(stb), .ack(ack), .we(we), .addr(addr),
    .dtw(dtw), .dtr(dtr), .irq(irq), .u_data_o(u_data_o), .u_write_o(u_write_o),
    .u_busy_i(u_busy_i), .u_data_i(u_data_i), .u_ready_i(u_ready_i),
    .u_ack_o(u_ack_o), .u_clkdiv_o(u_clkdiv_o), .u_cfg_o(u_cfg_o)
  );

  always #5 clk = ~clk;

  int passes = 0, total = 0;

  // reference model
  logic [7:0]    tx_q[$];
  logic [7:0]    rx_q[$];
  bit            m_tx_ovf = 0, m_rx_ovf = 0, m_active = 0;
  logic [5:0]    m_ctrl = '0;
  logic [CW-1:0] m_clkdiv = '0;

  typedef struct { string name; logic [31:0] val; } rd_t;
  rd_t rd_q[$];

  // core emulation knobs
  int busy_len = 10;
  bit rand_busy = 0, hold_busy = 0;
  int ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: got event, want none", name);
  endtask

  function automatic logic [31:0] m_status();
    int tc = tx_q.size();
    int rc = rx_q.size();
    logic [31:0] s = '0;
    s[0] = (tc == DEPTH);
    s[1] = (tc == 0);
    s[2] = (rc == DEPTH);
    s[3] = (rc == 0);
    s[4] = m_tx_ovf;
    s[5] = m_rx_ovf;
    s[6] = m_active;
    s[11:8]  = tc[3:0];
    s[15:12] = rc[3:0];
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[0] && rx_q.size() != 0) || (m_ctrl[1] && tx_q.size() == 0 && !m_active)
        || (m_ctrl[2] && (m_tx_ovf || m_rx_ovf));
  endfunction

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    stb = 1; we = 1; addr = a; dtw = d;
    case (a)
      2'd0: if (tx_q.size() < DEPTH) tx_q.push_back(d[7:0]); else m_tx_ovf = 1;
      2'd1: begin if (d[4]) m_tx_ovf = 0; if (d[5]) m_rx_ovf = 0; end
      2'd2: m_ctrl = d[5:0];
      default: m_clkdiv = d[CW-1:0];
    endcase
    @(posedge clk); #1;
    stb = 0; we = 0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input string name);
    rd_t r;
    @(posedge clk); #1;
    stb = 1; we = 0; addr = a;
    r.name = name;
    case (a)
      2'd0:    r.val = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
      2'd1:    r.val = m_status();
      2'd2:    r.val = {26'h0, m_ctrl};
      default: r.val = {16'h0, m_clkdiv};
    endcase
    rd_q.push_back(r);
    @(posedge clk); #1;
    stb = 0;
  endtask

  task automatic rx_send(input logic [7:0] b, input int hold, input string name);
    int a0 = ack_cnt;
    @(posedge clk); #1;
    u_data_i = b; u_ready_i = 1;
    if (rx_q.size() < DEPTH) rx_q.push_back(b); else m_rx_ovf = 1;
    repeat (hold) @(posedge clk);
    #1 u_ready_i = 0;
    repeat (2) @(posedge clk);
    #1 check(name, 32'(ack_cnt - a0), 32'd1);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while ((tx_q.size() != 0 || u_busy_i) && n < 3000) begin
      @(posedge clk); n++;
    end
    if (n >= 3000) fail_now("tx_drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_irq_quiet(input string name);
    repeat (2) @(posedge clk);
    #1 check(name, 32'(irq), 32'(m_irq()));
  endtask

  // monitor + core emulation, all on the falling edge
  initial begin
    int busy_cnt = 0;
    bit prev_write = 0;
    rd_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0; u_busy_i = 0; prev_write = 0;
        continue;
      end
      if (u_write_o) begin
        check("write_while_busy", 32'(u_busy_i), 32'd0);
        check("write_pulse_width", 32'(prev_write), 32'd0);
        if (tx_q.size() == 0) fail_now("tx_unexpected_write");
        else check("tx_byte", 32'(u_data_o), 32'(tx_q.pop_front()));
      end
      prev_write = u_write_o;
      if (u_ack_o) ack_cnt++;
      if (stb && !we) begin
        if (rd_q.size() == 0) fail_now("rd_unexpected");
        else begin
          r = rd_q.pop_front();
          check(r.name, dtr, r.val);
        end
      end
      if (busy_cnt > 0) busy_cnt--;
      if (u_write_o) busy_cnt = rand_busy ? $urandom_range(2, 10) : busy_len;
      u_busy_i = hold_busy || (busy_cnt > 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // reset state
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_write", 32'(u_write_o), 32'd0);
    check("rst_uack", 32'(u_ack_o), 32'd0);
    check("rst_bus_ack", 32'(ack), 32'd1);
    bus_rd(2'd0, "rst_data");
    bus_rd(2'd1, "rst_status");
    bus_rd(2'd2, "rst_ctrl");
    bus_rd(2'd3, "rst_clkdiv");

    // two bytes, 10-cycle busy per byte
    busy_len = 10;
    bus_wr(2'd0, 32'h41);
    bus_wr(2'd0, 32'h42);
    wait_tx_idle();
    bus_rd(2'd1, "tx2_status");

    // TX overflow with busy held
    hold_busy = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 9; i++) bus_wr(2'd0, 32'h80 + i);
    bus_rd(2'd1, "txovf_status");
    bus_wr(2'd2, 32'h04);
    check_irq_quiet("irq_err_set");
    bus_wr(2'd1, 32'h10);
    bus_rd(2'd1, "txovf_clr_status");
    check_irq_quiet("irq_err_clr");
    bus_wr(2'd2, 32'h00);
    hold_busy = 0;
    wait_tx_idle();
    bus_rd(2'd1, "txovf_drained");

    // ready held 5 cycles -> exactly one ack
    rx_send(8'h5A, 5, "rx_one_ack");
    bus_rd(2'd1, "rx_status_cnt1");
    bus_rd(2'd0, "rx_data_5a");
    bus_rd(2'd1, "rx_status_empty");
    bus_rd(2'd0, "rx_empty_read");

    // irq latency on receive and on pop
    bus_wr(2'd2, 32'h01);
    bus_rd(2'd2, "ctrl_ie_rx");
    @(posedge clk); #1;
    u_data_i = 8'h77; u_ready_i = 1; rx_q.push_back(8'h77);
    @(posedge clk); #1;
    check("irq_at_push", 32'(irq), 32'd0);
    u_ready_i = 0;
    @(posedge clk); #1;
    check("irq_after_push", 32'(irq), 32'd1);
    stb = 1; we = 0; addr = 2'd0;
    rd_q.push_back('{"irq_rd_data", {24'h0, rx_q.pop_front()}});
    @(posedge clk); #1;
    stb = 0;
    check("irq_at_pop", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check("irq_after_pop", 32'(irq), 32'd0);

    // RX overflow and tx-empty interrupt
    for (int i = 0; i < 9; i++) rx_send(8'hC0 + 8'(i), 1, "rxovf_ack");
    bus_rd(2'd1, "rxovf_status");
    bus_wr(2'd1, 32'h20);
    bus_rd(2'd1, "rxovf_clr_status");
    for (int i = 0; i < DEPTH; i++) bus_rd(2'd0, "rxovf_data");
    bus_wr(2'd2, 32'h02);
    check_irq_quiet("irq_tx_empty");

    // configuration outputs
    bus_wr(2'd2, 32'hFFFF_FFE8);
    bus_wr(2'd3, 32'hABCD_1234);
    bus_rd(2'd2, "ctrl_rb");
    bus_rd(2'd3, "clkdiv_rb");
    check("cfg_out", 32'(u_cfg_o), 32'(m_ctrl[5:3]));
    check("clkdiv_out", 32'(u_clkdiv_o), 32'(m_clkdiv));

    // randomized traffic
    rand_busy = 1;
    bus_wr(2'd2, 32'($urandom_range(0, 63)));
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0, 1: bus_wr(2'd0, 32'($urandom_range(0, 255)));
        2:    rx_send(8'($urandom_range(0, 255)), $urandom_range(1, 4), "rnd_rx_ack");
        3:    bus_rd(2'd0, "rnd_data");
        default: begin
          bus_wr(2'd3, $urandom);
          bus_rd(2'd3, "rnd_clkdiv");
        end
      endcase
    end
    wait_tx_idle();
    bus_rd(2'd1, "rnd_status");
    check_irq_quiet("rnd_irq");
    while (rx_q.size() != 0) bus_rd(2'd0, "rnd_flush");
    bus_wr(2'd1, 32'h30);
    bus_wr(2'd2, 32'h00);

    // reset mid-frame with 3 bytes queued
    rand_busy = 0;
    busy_len = 25;
    for (int i = 0; i < 4; i++) bus_wr(2'd0, 32'h60 + i);
    m_active = 1;
    bus_rd(2'd1, "midframe_status");
    @(posedge clk); #1;
    reset = 1;
    tx_q.delete(); rx_q.delete();
    m_tx_ovf = 0; m_rx_ovf = 0; m_active = 0; m_ctrl = '0; m_clkdiv = '0;
    @(posedge clk); #1;
    check("rst_mid_write", 32'(u_write_o), 32'd0);
    reset = 0;
    bus_rd(2'd1, "rst_mid_status");
    check_irq_quiet("rst_mid_irq");
    repeat (5) @(posedge clk);
    if (rd_q.size() != 0) fail_now("rd_pending");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
